arbiter_rr_hold: RTL
====================

Name: arbiter_rr_hold

Overview:
- Registered round-robin arbiter for REQ_NUM requesters with grant hold (lock) and a bounded hold time.
- Built on the double-vector fixed-priority-from-base scheme already used in the arb library. A base register rotates so the requester after the last granted one gets highest priority.
- Sits in front of shared resources (buses, memory ports, shared FIFOs) where a master must keep ownership for a multi-cycle burst.

Parameters:
- REQ_NUM, 4, number of requesters (>=2).
- MAX_HOLD, 8, max consecutive cycles one grant may be held; 0 = unlimited.
- IDX_W, $clog2(REQ_NUM), width of gnt_id (derived, do not override).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  REQ_NUM  request vector, bit i = requester i.
- lock  input  REQ_NUM  bit i high = requester i wants to keep its grant next cycle.
- gnt  output  REQ_NUM  registered one-hot grant, 0 when idle.
- gnt_vld  output  1  high when gnt is non-zero.
- gnt_id  output  IDX_W  binary index of granted requester, 0 when idle.

Behaviour:
- One clock (clk); reset rst is asynchronous and active-high.
- Reset values: gnt=0, gnt_vld=0, gnt_id=0, base=one-hot bit 0, hold_cnt=0, state=IDLE.
- State machine, two states:
  - IDLE: no grant outstanding.
  - OWN: gnt holds one requester g.
- Decision function pick(r, b): the fixed-priority-from-base result.
  - double_r = {r,r}; x = ~(double_r - b) & double_r; result = upper half | lower half.
  - Gives the first set bit of r at or after b's position, wrapping.
  - Result is 0 when r = 0.
- IDLE, req != 0: gnt <= pick(req, base); go to OWN; hold_cnt <= 0.
  - Latency: request at edge n is granted visible after edge n+1 (1-cycle registered).
- IDLE, req = 0: stay IDLE, outputs 0.
- OWN, keep condition: req[g] & lock[g] & (MAX_HOLD==0 | hold_cnt < MAX_HOLD-1).
- OWN, keep true: gnt unchanged; hold_cnt <= hold_cnt+1 (saturating when MAX_HOLD==0).
- OWN, keep false (release):
  - base <= rotl(gnt, 1), i.e. one-hot of (g+1) mod REQ_NUM.
  - The same edge arbitrates again: gnt <= pick(req, rotl(gnt,1)), so back-to-back grants have no idle bubble.
  - If the result is non-zero, stay OWN with hold_cnt <= 0; else go to IDLE and gnt <= 0.
- lock=0 everywhere: one-cycle grants rotating each cycle.
- A forcibly released requester still requesting is re-granted only if no other requester is pending. It has the lowest priority after rotation.
- req[g] dropping while granted releases at the next edge. The grant that cycle stands; no combinational de-assert.
- lock is ignored for requesters not currently granted. lock without req is ignored.
- There is no preemption: arbitration happens only in IDLE or at release.
- Reset asserted mid-grant: outputs go to 0 immediately (async). base returns to bit 0.
- Invariants: gnt is always one-hot or zero. gnt & ~req is never set at a decision edge. gnt_id = encode(gnt).
- hold_cnt width: $clog2(MAX_HOLD+1), minimum 1.

Optional Feature:
- Macro: ARB_RR_HOLD_PRIO_EN.
- Defined:
  - Adds input prio[REQ_NUM-1:0].
  - At each decision point, if (req & prio) != 0, the arbiter uses pick(req & prio, base); else pick(req, base).
  - Round robin and rotation apply identically within the priority class. Still no preemption of an active hold.
- Undefined: no prio port; all requesters are equal class.

Test Plan (REQ_NUM=4, MAX_HOLD=4):
- Reset: assert rst with req=1111 -> gnt=0000, gnt_vld=0, gnt_id=0 during and one cycle after release. The first grant, on the 2nd edge after deassert, is 0001.
- Rotation: req=1111, lock=0000 held -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles; gnt_id 0,1,2,3,0.
- Hold limit: req=0101, lock=0100 from reset.
  - Expected gnt: 0001 (1 cycle), then 0100 for exactly 4 cycles, then 0001, then 0100 again.
- Early release and wrap: gnt=1000 with lock[3]=1, req changes to 1001 with lock[3]=0 -> next gnt=0001 with no idle cycle. Then req=0000 -> gnt=0000, gnt_vld=0.
- Async reset mid-hold: gnt=0100 holding, pulse rst between edges -> gnt=0 immediately. After release with req=1111, first gnt=0001.
- Prio (macro on): req=1111, prio=1000, lock=0 -> gnt=1000 every decision. Then prio=0000 -> next gnt=0001 (base rotated past 3).

Source files
------------

// File: rtl/arbiter_rr_hold.sv
`default_nettype none
// ============================================================================
// Module   : arbiter_rr_hold
// Purpose  : Registered round-robin arbiter with grant lock and bounded hold.
//            Optional priority class enabled by ARB_RR_HOLD_PRIO_EN.
// Revision : 1.0 - initial release
// ============================================================================
module arbiter_rr_hold #(
    parameter int REQ_NUM  = 4,
    parameter int MAX_HOLD = 8,
    parameter int IDX_W    = $clog2(REQ_NUM)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [REQ_NUM-1:0] req_i,
    input  logic [REQ_NUM-1:0] lock_i,
`ifdef ARB_RR_HOLD_PRIO_EN
    input  logic [REQ_NUM-1:0] prio_i,
`endif
    output logic [REQ_NUM-1:0] gnt_o,
    output logic               gnt_vld_o,
    output logic [IDX_W-1:0]   gnt_id_o
);

    localparam int HOLD_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    state_t             state_q;
    logic [REQ_NUM-1:0] gnt_q;
    logic               gnt_vld_q;
    logic [IDX_W-1:0]   gnt_id_q;
    logic [REQ_NUM-1:0] base_q;
    logic [HOLD_W-1:0]  hold_q;
    logic [HOLD_W-1:0]  hold_d;

    logic [REQ_NUM-1:0] w_cand;
    logic [REQ_NUM-1:0] w_rot;
    logic [REQ_NUM-1:0] w_pick_base;
    logic [REQ_NUM-1:0] w_pick_rot;
    logic               w_keep;

    // First set bit of r at or after the one-hot position b, wrapping around.
    function automatic logic [REQ_NUM-1:0] pick(input logic [REQ_NUM-1:0] r,
                                                input logic [REQ_NUM-1:0] b);
        logic [2*REQ_NUM-1:0] d;
        logic [2*REQ_NUM-1:0] x;
        d = {r, r};
        x = ~(d - {{REQ_NUM{1'b0}}, b}) & d;
        return x[2*REQ_NUM-1:REQ_NUM] | x[REQ_NUM-1:0];
    endfunction

    function automatic logic [IDX_W-1:0] encode(input logic [REQ_NUM-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (v[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

`ifdef ARB_RR_HOLD_PRIO_EN
    assign w_cand = (|(req_i & prio_i)) ? (req_i & prio_i) : req_i;
`else
    assign w_cand = req_i;
`endif

    assign w_rot       = {gnt_q[REQ_NUM-2:0], gnt_q[REQ_NUM-1]};
    assign w_pick_base = pick(w_cand, base_q);
    assign w_pick_rot  = pick(w_cand, w_rot);
    assign w_keep      = (|(gnt_q & req_i & lock_i)) &&
                         ((MAX_HOLD == 0) || (hold_q < HOLD_LAST));
    // Saturates so an unlimited hold never wraps the counter.
    assign hold_d      = (hold_q == {HOLD_W{1'b1}}) ? hold_q : hold_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            gnt_vld_q <= 1'b0;
            gnt_id_q  <= '0;
            base_q    <= {{(REQ_NUM-1){1'b0}}, 1'b1};
            hold_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|req_i) begin
                        state_q   <= S_OWN;
                        gnt_q     <= w_pick_base;
                        gnt_vld_q <= 1'b1;
                        gnt_id_q  <= encode(w_pick_base);
                        hold_q    <= '0;
                    end
                end
                S_OWN: begin
                    if (w_keep) begin
                        hold_q <= hold_d;
                    end else begin
                        // Release and re-arbitrate on the same edge: no idle bubble.
                        base_q    <= w_rot;
                        gnt_q     <= w_pick_rot;
                        gnt_vld_q <= |w_pick_rot;
                        gnt_id_q  <= encode(w_pick_rot);
                        hold_q    <= '0;
                        state_q   <= (|w_pick_rot) ? S_OWN : S_IDLE;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    gnt_q     <= '0;
                    gnt_vld_q <= 1'b0;
                    gnt_id_q  <= '0;
                end
            endcase
        end
    end

    assign gnt_o     = gnt_q;
    assign gnt_vld_o = gnt_vld_q;
    assign gnt_id_o  = gnt_id_q;

endmodule
`default_nettype wire
